hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RV core; the producer side of the ID/EX enable/flush interface.
- Combines four hazard sources into per-register enable and flush controls for PC, IF/ID, ID/EX and EX/MEM:
  - data-memory wait
  - multi-cycle EX operations (mul/div)
  - taken branches
  - load-use dependencies
- Tracks multi-cycle operations with an FSM and watchdog, and keeps saturating stall and flush statistics counters.

---
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: hazard sources from the pipeline plus the per-stage
// enable/flush controls and statistics driven back by the controller.
//   master : hazard controller (consumes hazard sources, drives controls)
//   slave  : pipeline datapath (drives hazard sources, consumes controls)
interface hazard_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
) ();
  // Hazard sources
  logic                 dmem_wait;
  logic                 ex_mc_start;
  logic                 ex_mc_done;
  logic                 branch_taken;
  logic                 idex_memread;
  logic [4:0]           idex_rd;
  logic [4:0]           ifid_rs1;
  logic [4:0]           ifid_rs2;
  logic                 ifid_uses_rs1;
  logic                 ifid_uses_rs2;
  // Pipeline controls
  logic                 pc_enable;
  logic                 ifid_enable;
  logic                 ifid_flush;
  logic                 idex_enable;
  logic                 idex_flush;
  logic                 exmem_enable;
  logic                 exmem_flush;
  // Status
  logic                 mc_timeout;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    input  dmem_wait, ex_mc_start, ex_mc_done, branch_taken, idex_memread,
           idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
    output pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
           exmem_enable, exmem_flush, mc_timeout, stall_count, flush_count
  );

  modport slave (
    output dmem_wait, ex_mc_start, ex_mc_done, branch_taken, idex_memread,
           idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
    input  pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
           exmem_enable, exmem_flush, mc_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Merges data-memory wait, multi-cycle EX ops, taken branches and load-use
// dependencies into enable/flush controls for PC, IF/ID, ID/EX and EX/MEM.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   hz      : hazard_ctrl_if master (hazard inputs, control/status outputs)
// Control outputs are combinational; counters and mc_timeout are registered.
module hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic           clk,
  input logic           reset_n,
  hazard_ctrl_if.master hz
);

  localparam int unsigned WaitW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [0:0] {StRun, StMcWait} state_e;

  state_e               state_q, state_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 mc_timeout_q, mc_timeout_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;

  logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl;
  logic br_flush;
  logic load_use;

  // A load to x0 never creates a dependency.
  assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                    ((hz.ifid_uses_rs1 && (hz.ifid_rs1 == hz.idex_rd)) ||
                     (hz.ifid_uses_rs2 && (hz.ifid_rs2 == hz.idex_rd)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mc_timeout_d = 1'b0;
    br_flush     = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_fl      = 1'b0;
    idex_en      = 1'b1;
    idex_fl      = 1'b0;
    exmem_en     = 1'b1;
    exmem_fl     = 1'b0;

    if (!reset_n) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (hz.dmem_wait) begin
      // Whole pipe frozen; FSM and watchdog hold their values.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.ex_mc_start && !hz.ex_mc_done) begin
            // MC stall outranks a simultaneous branch.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_fl = 1'b1;
            state_d  = StMcWait;
            wait_d   = WaitW'(1);
          end else if (hz.branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use is moot.
            ifid_fl  = 1'b1;
            idex_fl  = 1'b1;
            br_flush = 1'b1;
          end else if (load_use) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_fl = 1'b1;
          end
        end
        StMcWait: begin
          if (hz.ex_mc_done) begin
            state_d = StRun;
            wait_d  = '0;
          end else begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_fl = 1'b1;
            if (wait_q == WaitW'(MC_TIMEOUT)) begin
              // Op considered lost; resume fetching.
              state_d      = StRun;
              wait_d       = '0;
              mc_timeout_d = 1'b1;
            end else begin
              wait_d = wait_q + WaitW'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && (stall_q != {CNT_WIDTH{1'b1}})) stall_d = stall_q + 1'b1;
    if (br_flush && (flush_q != {CNT_WIDTH{1'b1}})) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      wait_q       <= '0;
      mc_timeout_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      mc_timeout_q <= mc_timeout_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  assign hz.pc_enable    = pc_en;
  assign hz.ifid_enable  = ifid_en;
  assign hz.ifid_flush   = ifid_fl;
  assign hz.idex_enable  = idex_en;
  assign hz.idex_flush   = idex_fl;
  assign hz.exmem_enable = exmem_en;
  assign hz.exmem_flush  = exmem_fl;
  assign hz.mc_timeout   = mc_timeout_q;
  assign hz.stall_count  = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // Control vector order: {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl}
  localparam logic [6:0] CTL_DEF = 7'b1101010;
  localparam logic [6:0] CTL_OFF = 7'b0000000;
  localparam logic [6:0] CTL_MC  = 7'b0000011;
  localparam logic [6:0] CTL_LU  = 7'b0001110;
  localparam logic [6:0] CTL_BR  = 7'b1111110;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dmem_wait, ex_mc_start, ex_mc_done, branch_taken, idex_memread;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       ifid_uses_rs1, ifid_uses_rs2;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_WIDTH(32)) hz ();
  hazard_ctrl_if #(.CNT_WIDTH(4))  hz_wd ();

  // Main instance uses default parameters; second has a short watchdog and
  // narrow counters for boundary checks. Both see identical stimulus.
  hazard_ctrl dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (hz)
  );

  hazard_ctrl #(.MC_TIMEOUT(4), .CNT_WIDTH(4)) dut_wd (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (hz_wd)
  );

  assign hz.dmem_wait        = dmem_wait;
  assign hz.ex_mc_start      = ex_mc_start;
  assign hz.ex_mc_done       = ex_mc_done;
  assign hz.branch_taken     = branch_taken;
  assign hz.idex_memread     = idex_memread;
  assign hz.idex_rd          = idex_rd;
  assign hz.ifid_rs1         = ifid_rs1;
  assign hz.ifid_rs2         = ifid_rs2;
  assign hz.ifid_uses_rs1    = ifid_uses_rs1;
  assign hz.ifid_uses_rs2    = ifid_uses_rs2;
  assign hz_wd.dmem_wait     = dmem_wait;
  assign hz_wd.ex_mc_start   = ex_mc_start;
  assign hz_wd.ex_mc_done    = ex_mc_done;
  assign hz_wd.branch_taken  = branch_taken;
  assign hz_wd.idex_memread  = idex_memread;
  assign hz_wd.idex_rd       = idex_rd;
  assign hz_wd.ifid_rs1      = ifid_rs1;
  assign hz_wd.ifid_rs2      = ifid_rs2;
  assign hz_wd.ifid_uses_rs1 = ifid_uses_rs1;
  assign hz_wd.ifid_uses_rs2 = ifid_uses_rs2;

  logic [6:0] ctl, ctl_wd;
  assign ctl    = {hz.pc_enable, hz.ifid_enable, hz.ifid_flush, hz.idex_enable,
                   hz.idex_flush, hz.exmem_enable, hz.exmem_flush};
  assign ctl_wd = {hz_wd.pc_enable, hz_wd.ifid_enable, hz_wd.ifid_flush, hz_wd.idex_enable,
                   hz_wd.idex_flush, hz_wd.exmem_enable, hz_wd.exmem_flush};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    dmem_wait = 0; ex_mc_start = 0; ex_mc_done = 0; branch_taken = 0; idex_memread = 0;
    idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs1 = 0; ifid_uses_rs2 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    #3;
    tests++; if (ctl !== CTL_OFF) begin failed++; $display("FAIL rst_ctl: got %b want %b", ctl, CTL_OFF); end
    tick();
    tick();
    tests++; if (hz.stall_count !== 32'd0) begin failed++; $display("FAIL rst_stall: got %0d want 0", hz.stall_count); end
    tests++; if (hz.flush_count !== 32'd0) begin failed++; $display("FAIL rst_flush: got %0d want 0", hz.flush_count); end
    tests++; if (hz.mc_timeout !== 1'b0) begin failed++; $display("FAIL rst_to: got %b want 0", hz.mc_timeout); end
    reset_n = 1;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL rst_def: got %b want %b", ctl, CTL_DEF); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; ifid_uses_rs1 = 1; ifid_rs2 = 1;
    mid();
    tests++; if (ctl !== CTL_LU) begin failed++; $display("FAIL lu_ctl: got %b want %b", ctl, CTL_LU); end
    tick();
    tests++; if (hz.stall_count !== 32'd1) begin failed++; $display("FAIL lu_stall: got %0d want 1", hz.stall_count); end
    idex_memread = 0;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL lu_after: got %b want %b", ctl, CTL_DEF); end
    tick();
    idex_memread = 1; idex_rd = 0; ifid_rs1 = 0;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL lu_x0: got %b want %b", ctl, CTL_DEF); end
    tick();
    idex_rd = 7; ifid_rs1 = 3; ifid_rs2 = 7; ifid_uses_rs1 = 1; ifid_uses_rs2 = 1;
    mid();
    tests++; if (ctl !== CTL_LU) begin failed++; $display("FAIL lu_rs2: got %b want %b", ctl, CTL_LU); end
    tick();
    ifid_uses_rs2 = 0;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL lu_unused: got %b want %b", ctl, CTL_DEF); end
    tick();
    tests++; if (hz.stall_count !== 32'd2) begin failed++; $display("FAIL lu_stall2: got %0d want 2", hz.stall_count); end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; ifid_uses_rs1 = 1; branch_taken = 1;
    mid();
    tests++; if (ctl !== CTL_BR) begin failed++; $display("FAIL br_ctl: got %b want %b", ctl, CTL_BR); end
    tick();
    tests++; if (hz.flush_count !== 32'd1) begin failed++; $display("FAIL br_flush: got %0d want 1", hz.flush_count); end
    tests++; if (hz.stall_count !== 32'd0) begin failed++; $display("FAIL br_stall: got %0d want 0", hz.stall_count); end
    clear_inputs();
    ex_mc_start = 1; branch_taken = 1;
    mid();
    tests++; if (ctl !== CTL_MC) begin failed++; $display("FAIL br_vs_mc: got %b want %b", ctl, CTL_MC); end
    tick();
    tests++; if (hz.flush_count !== 32'd1) begin failed++; $display("FAIL br_ignored: got %0d want 1", hz.flush_count); end
    clear_inputs();
  endtask

  task automatic test_mc();
    do_reset();
    ex_mc_start = 1;
    mid();
    tests++; if (ctl !== CTL_MC) begin failed++; $display("FAIL mc_start: got %b want %b", ctl, CTL_MC); end
    tick();
    ex_mc_start = 0;
    for (int i = 1; i <= 4; i++) begin
      mid();
      tests++; if (ctl !== CTL_MC) begin failed++; $display("FAIL mc_wait%0d: got %b want %b", i, ctl, CTL_MC); end
      tick();
    end
    ex_mc_done = 1;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL mc_done: got %b want %b", ctl, CTL_DEF); end
    tick();
    tests++; if (hz.stall_count !== 32'd5) begin failed++; $display("FAIL mc_stall: got %0d want 5", hz.stall_count); end
    ex_mc_done = 0; branch_taken = 1;
    mid();
    tests++; if (ctl !== CTL_BR) begin failed++; $display("FAIL mc_run: got %b want %b", ctl, CTL_BR); end
    tick();
    branch_taken = 0; ex_mc_start = 1; ex_mc_done = 1;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL mc_same: got %b want %b", ctl, CTL_DEF); end
    tick();
    ex_mc_start = 0; ex_mc_done = 0; branch_taken = 1;
    mid();
    tests++; if (ctl !== CTL_BR) begin failed++; $display("FAIL mc_same_run: got %b want %b", ctl, CTL_BR); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mc_dmem();
    do_reset();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    tick();
    tick();
    dmem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      tests++; if (ctl !== CTL_OFF) begin failed++; $display("FAIL mcd_off%0d: got %b want %b", i, ctl, CTL_OFF); end
      tick();
    end
    dmem_wait = 0;
    for (int i = 0; i < 2; i++) begin
      mid();
      tests++; if (ctl !== CTL_MC) begin failed++; $display("FAIL mcd_wait%0d: got %b want %b", i, ctl, CTL_MC); end
      tick();
    end
    ex_mc_done = 1;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL mcd_done: got %b want %b", ctl, CTL_DEF); end
    tick();
    tests++; if (hz.stall_count !== 32'd8) begin failed++; $display("FAIL mcd_stall: got %0d want 8", hz.stall_count); end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    ex_mc_start = 1;
    mid();
    tests++; if (ctl_wd !== CTL_MC) begin failed++; $display("FAIL wd_start: got %b want %b", ctl_wd, CTL_MC); end
    tick();
    ex_mc_start = 0;
    for (int i = 1; i <= 4; i++) begin
      mid();
      tests++; if (ctl_wd !== CTL_MC) begin failed++; $display("FAIL wd_wait%0d: got %b want %b", i, ctl_wd, CTL_MC); end
      tests++; if (hz_wd.mc_timeout !== 1'b0) begin failed++; $display("FAIL wd_early%0d: got %b want 0", i, hz_wd.mc_timeout); end
      tick();
    end
    mid();
    tests++; if (hz_wd.mc_timeout !== 1'b1) begin failed++; $display("FAIL wd_pulse: got %b want 1", hz_wd.mc_timeout); end
    tests++; if (ctl_wd !== CTL_DEF) begin failed++; $display("FAIL wd_resume: got %b want %b", ctl_wd, CTL_DEF); end
    tick();
    tests++; if (hz_wd.mc_timeout !== 1'b0) begin failed++; $display("FAIL wd_once: got %b want 0", hz_wd.mc_timeout); end
    tests++; if (hz_wd.stall_count !== 4'd5) begin failed++; $display("FAIL wd_stall: got %0d want 5", hz_wd.stall_count); end
    // Watchdog paused by dmem_wait: start, wait 1, 3 frozen cycles, waits 2..4, then pulse.
    do_reset();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    tick();
    dmem_wait = 1;
    tick(); tick(); tick();
    dmem_wait = 0;
    for (int i = 2; i <= 4; i++) begin
      mid();
      tests++; if (ctl_wd !== CTL_MC) begin failed++; $display("FAIL wdd_wait%0d: got %b want %b", i, ctl_wd, CTL_MC); end
      tests++; if (hz_wd.mc_timeout !== 1'b0) begin failed++; $display("FAIL wdd_early%0d: got %b want 0", i, hz_wd.mc_timeout); end
      tick();
    end
    tests++; if (hz_wd.mc_timeout !== 1'b1) begin failed++; $display("FAIL wdd_pulse: got %b want 1", hz_wd.mc_timeout); end
    tests++; if (hz_wd.stall_count !== 4'd8) begin failed++; $display("FAIL wdd_stall: got %0d want 8", hz_wd.stall_count); end
    tick();
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    dmem_wait = 1;
    for (int i = 0; i < 20; i++) tick();
    dmem_wait = 0;
    mid();
    tests++; if (hz_wd.stall_count !== 4'hF) begin failed++; $display("FAIL sat_wd: got %0d want 15", hz_wd.stall_count); end
    tests++; if (hz.stall_count !== 32'd20) begin failed++; $display("FAIL sat_main: got %0d want 20", hz.stall_count); end
    tick();
  endtask

  task automatic test_reset_mid_mc();
    do_reset();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    tick(); tick(); tick();
    // Both instances are in MC_WAIT; the short watchdog is at its last count.
    reset_n = 0;
    #1;
    tests++; if (ctl !== CTL_OFF) begin failed++; $display("FAIL rmid_ctl: got %b want %b", ctl, CTL_OFF); end
    tests++; if (hz.stall_count !== 32'd0) begin failed++; $display("FAIL rmid_stall: got %0d want 0", hz.stall_count); end
    tick();
    tests++; if (hz_wd.mc_timeout !== 1'b0) begin failed++; $display("FAIL rmid_to: got %b want 0", hz_wd.mc_timeout); end
    tick();
    reset_n = 1;
    mid();
    tests++; if (ctl !== CTL_DEF) begin failed++; $display("FAIL rmid_def: got %b want %b", ctl, CTL_DEF); end
    tick();
    tests++; if (hz_wd.mc_timeout !== 1'b0) begin failed++; $display("FAIL rmid_to2: got %b want 0", hz_wd.mc_timeout); end
    branch_taken = 1;
    mid();
    tests++; if (ctl !== CTL_BR) begin failed++; $display("FAIL rmid_run: got %b want %b", ctl, CTL_BR); end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mc();
    test_mc_dmem();
    test_watchdog();
    test_saturate();
    test_reset_mid_mc();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
